rv_trace_checker: RTL and testbench
===================================

# rv_trace_checker

Parametrised, synthesizable self-checking monitor for the RV32I core. It watches the core's next-PC and write-back streams and compares each write-back value against a preloaded expected trace. It reports pass, fail (with the failing index and value) or hang (PC stalled). It sits beside the core in the test harness and replaces open-loop `$monitor` inspection with cycle-exact, on-chip checking.

## Interface
- XLEN, 32, datapath width of NPC and write-back values
- DEPTH, 16, number of expected-trace entries (power of two, ≥2)
- STALL_LIMIT, 64, consecutive cycles of unchanged NPC that declare a hang
- CNT_W, 16, width of cycle counter
- clk  in  1  clock, rising edge
- RN  in  1  asynchronous active-low reset
- start  in  1  begin a run (single-cycle pulse)
- num_exp  in  $clog2(DEPTH)+1  entries to check this run, sampled on start; 1..DEPTH
- exp_we  in  1  expected-trace write strobe
- exp_addr  in  $clog2(DEPTH)  write address
- exp_data  in  XLEN  expected value
- npc  in  XLEN  core next-PC
- wb_valid  in  1  core write-back qualifier
- wb_data  in  XLEN  core write-back value
- busy  out  1  state is RUN
- done  out  1  run ended (PASS, FAIL or HANG)
- pass  out  1  all num_exp entries matched
- fail  out  1  mismatch detected
- hang  out  1  stall limit reached
- err_idx  out  $clog2(DEPTH)  index of first mismatch
- err_got  out  XLEN  wb_data at first mismatch
- cycle_cnt  out  CNT_W  cycles spent in RUN, saturating

## Operation
- States: IDLE, RUN, PASS, FAIL, HANG. Reset → IDLE.
- IDLE/PASS/FAIL/HANG + start → RUN. On entry: idx=0, stall_cnt=0, cycle_cnt=0, err_* cleared, flags cleared, num_exp latched (0 is treated as DEPTH).
- exp_we honoured only when state ≠ RUN; ignored during RUN. Write and start in the same cycle: the write completes, and the run uses the new value.
- RUN, wb_valid=1: compare wb_data with exp[idx].
  - Mismatch → FAIL; err_idx=idx, err_got=wb_data.
  - Match with idx=num_exp-1 → PASS.
  - Any other match → idx+1.
- RUN, stall: npc equal to its previous-cycle value increments stall_cnt, otherwise stall_cnt=0. stall_cnt reaching STALL_LIMIT-1 while npc is still unchanged → HANG.
- Priority in one cycle: FAIL > PASS > HANG.
- wb_valid outside RUN is ignored.
- cycle_cnt increments every RUN cycle and saturates at all-ones.
- Terminal states hold all outputs until start or reset.
- start during RUN is ignored.

## Timing
- All outputs are registered. Reset values: every output 0, state IDLE.
- Compare is combinational on the wb_valid cycle. Verdict flags and err_* become visible the next cycle (1-cycle latency).
- busy rises the cycle after start.
- The first npc sample in RUN seeds the previous-PC register and does not count as a stall.
- HANG asserts exactly STALL_LIMIT cycles after the last npc change.
- Asserting RN low mid-run immediately forces IDLE and clears all outputs. Expected-trace memory contents are not reset.

## Structure
- Shared package rv_chk_pkg: state enum (IDLE, RUN, PASS, FAIL, HANG) and default parameter constants.
- Sub-module rv_chk_exp_ram: DEPTH×XLEN storage with one write port and one combinational read port.
- Top-level rv_trace_checker contains the FSM, counters and capture registers.

## Test plan
- **Pass run:** load exp[0..3]=0x5,0xA,0xF,0x14; num_exp=4; start; four matching wb_valid pulses → pass=1, done=1 one cycle after the 4th pulse.
- **Mismatch:** same load; wb sequence 0x5,0xB → fail=1, err_idx=1, err_got=0x0000000B; later wb_valid pulses change nothing.
- **Hang:** STALL_LIMIT=8; npc held at 0x40 after start → hang=1 exactly 8 cycles after the last change; cycle_cnt is consistent.
- **Simultaneous events:** final-entry match on the cycle the stall limit is hit → pass=1, hang=0. Mismatch on the same cycle → fail=1, hang=0.
- **Reset mid-run:** RN low during RUN with idx=2 → all outputs 0 asynchronously. Restart with start → idx restarts at 0 and the memory still holds the loaded values.
- **Locked writes / restart:** exp_we during RUN leaves the memory unchanged. start from FAIL clears err_* and begins a new run. num_exp=0 checks all DEPTH entries.

Source files
------------

// File: rtl/rv_chk_pkg.sv
// Shared types and default sizing for the RV32I trace checker.
// No logic; imported by the checker top and its expected-trace RAM.
package rv_chk_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    PASS = 3'd2,
    FAIL = 3'd3,
    HANG = 3'd4
  } chk_state_t;

  localparam int unsigned DEF_XLEN        = 32;
  localparam int unsigned DEF_DEPTH       = 16;
  localparam int unsigned DEF_STALL_LIMIT = 64;
  localparam int unsigned DEF_CNT_W       = 16;

endpackage

// File: rtl/rv_chk_exp_ram.sv
// Expected-trace storage: one synchronous write port, one combinational read port.
// Write lands on the next clk edge; contents are deliberately not reset.
module rv_chk_exp_ram #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rv_trace_checker.sv
// Compares core write-back values against a preloaded trace and flags pass/fail/hang.
// Verdicts appear one cycle after the deciding sample; no backpressure, core is never stalled.
module rv_trace_checker
  import rv_chk_pkg::*;
#(
  parameter int XLEN        = DEF_XLEN,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int STALL_LIMIT = DEF_STALL_LIMIT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     RN,
  input  logic                     start,
  input  logic [$clog2(DEPTH):0]   num_exp,
  input  logic                     exp_we,
  input  logic [$clog2(DEPTH)-1:0] exp_addr,
  input  logic [XLEN-1:0]          exp_data,
  input  logic [XLEN-1:0]          npc,
  input  logic                     wb_valid,
  input  logic [XLEN-1:0]          wb_data,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     fail,
  output logic                     hang,
  output logic [$clog2(DEPTH)-1:0] err_idx,
  output logic [XLEN-1:0]          err_got,
  output logic [CNT_W-1:0]         cycle_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STALL_LIMIT) + 1;

  chk_state_t      state;
  logic [AW-1:0]   idx;
  logic [AW-1:0]   last_idx;
  logic [SW-1:0]   stall_cnt;
  logic [SW-1:0]   stall_nxt;
  logic [XLEN-1:0] prev_npc;
  logic            seeded;
  logic [XLEN-1:0] exp_rd;
  logic [AW:0]     num_eff;
  logic            ram_we;
  logic            wb_mismatch;
  logic            wb_last;
  logic            npc_same;
  logic            stall_hit;

  // Trace is frozen while a run is in progress.
  assign ram_we = exp_we && (state != RUN);

  rv_chk_exp_ram #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_exp_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (exp_addr),
    .wdata (exp_data),
    .raddr (idx),
    .rdata (exp_rd)
  );

  assign num_eff     = (num_exp == '0) ? (AW+1)'(DEPTH) : num_exp;
  assign wb_mismatch = wb_valid && (wb_data != exp_rd);
  assign wb_last     = wb_valid && !wb_mismatch && (idx == last_idx);
  assign npc_same    = seeded && (npc == prev_npc);
  assign stall_nxt   = stall_cnt + 1'b1;
  assign stall_hit   = npc_same && (stall_nxt == SW'(STALL_LIMIT - 1));

  always_ff @(posedge clk or negedge RN) begin
    if (!RN) begin
      state     <= IDLE;
      idx       <= '0;
      last_idx  <= '0;
      stall_cnt <= '0;
      prev_npc  <= '0;
      seeded    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      hang      <= 1'b0;
      err_idx   <= '0;
      err_got   <= '0;
      cycle_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (cycle_cnt != {CNT_W{1'b1}}) cycle_cnt <= cycle_cnt + 1'b1;
          prev_npc  <= npc;
          seeded    <= 1'b1;
          stall_cnt <= npc_same ? stall_nxt : '0;
          // Verdict priority: mismatch, then completed trace, then stall.
          if (wb_mismatch) begin
            state   <= FAIL;
            busy    <= 1'b0;
            done    <= 1'b1;
            fail    <= 1'b1;
            err_idx <= idx;
            err_got <= wb_data;
          end else if (wb_last) begin
            state <= PASS;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= 1'b1;
          end else if (stall_hit) begin
            state <= HANG;
            busy  <= 1'b0;
            done  <= 1'b1;
            hang  <= 1'b1;
          end else if (wb_valid) begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          if (start) begin
            state     <= RUN;
            idx       <= '0;
            last_idx  <= AW'(num_eff - 1'b1);
            stall_cnt <= '0;
            seeded    <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            hang      <= 1'b0;
            err_idx   <= '0;
            err_got   <= '0;
            cycle_cnt <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_trace_checker.sv
// Self-checking bench for rv_trace_checker: table-driven runs plus hand-written corner sequences.
module tb_rv_trace_checker;

  logic        clk;
  logic        RN;
  logic        start;
  logic [4:0]  num_exp;
  logic        exp_we;
  logic [3:0]  exp_addr;
  logic [31:0] exp_data;
  logic [31:0] npc;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic        busy, done, pass, fail, hang;
  logic [3:0]  err_idx;
  logic [31:0] err_got;
  logic [15:0] cycle_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        pass;
    logic        fail;
    logic        hang;
    logic [3:0]  err_idx;
    logic [31:0] err_got;
    logic [15:0] cyc;
  } verdict_t;

  typedef struct {
    logic [4:0] num;
    int         nwb;
    int         bad;
    verdict_t   v;
  } row_t;

  verdict_t sb[$];
  row_t     rows[6];
  logic     done_q;

  rv_trace_checker #(
    .XLEN(32), .DEPTH(16), .STALL_LIMIT(8), .CNT_W(16)
  ) dut (
    .clk(clk), .RN(RN), .start(start), .num_exp(num_exp),
    .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data),
    .npc(npc), .wb_valid(wb_valid), .wb_data(wb_data),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .hang(hang),
    .err_idx(err_idx), .err_got(err_got), .cycle_cnt(cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic verdict_t mkv(logic p, logic f, logic h, logic [3:0] ei,
                                   logic [31:0] eg, logic [15:0] c);
    verdict_t v;
    v.pass = p; v.fail = f; v.hang = h; v.err_idx = ei; v.err_got = eg; v.cyc = c;
    return v;
  endfunction

  // Scoreboard: each verdict edge pops the expectation pushed when its run was started.
  always @(negedge clk) begin
    if (done && !done_q) begin
      if (sb.size() == 0) begin
        check("unexpected_verdict", 64'd1, 64'd0);
      end else begin
        verdict_t v;
        v = sb.pop_front();
        check("sb_pass", pass, v.pass);
        check("sb_fail", fail, v.fail);
        check("sb_hang", hang, v.hang);
        check("sb_err_idx", err_idx, v.err_idx);
        check("sb_err_got", err_got, v.err_got);
        check("sb_cycle_cnt", cycle_cnt, v.cyc);
      end
    end
    done_q = done;
  end

  task automatic do_start(input logic [4:0] n);
    start = 1'b1; num_exp = n; npc = npc + 4;
    step();
    start = 1'b0;
  endtask

  task automatic run_row(input row_t r);
    int end_at;
    end_at = (r.bad >= 0) ? r.bad : r.nwb - 1;
    sb.push_back(r.v);
    do_start(r.num);
    check("row_busy_rise", busy, 1'b1);
    check("row_cnt_cleared", cycle_cnt, 16'd0);
    for (int i = 0; i < r.nwb; i++) begin
      wb_valid = 1'b1;
      wb_data  = (i == r.bad) ? 32'(5 * (i + 1) + 1) : 32'(5 * (i + 1));
      npc      = npc + 4;
      step();
      check("row_done_timing", done, (i >= end_at));
    end
    wb_valid = 1'b0;
    npc = npc + 4; step();
    npc = npc + 4; step();
    check("hold_pass", pass, r.v.pass);
    check("hold_fail", fail, r.v.fail);
    check("hold_hang", hang, 1'b0);
    check("hold_err_idx", err_idx, r.v.err_idx);
    check("hold_err_got", err_got, r.v.err_got);
    check("hold_cycle_cnt", cycle_cnt, r.v.cyc);
    check("hold_busy", busy, 1'b0);
  endtask

  initial begin
    rows[0] = '{num: 5'd4,  nwb: 4,  bad: -1, v: mkv(1, 0, 0, 4'd0,  32'h0,  16'd4)};
    rows[1] = '{num: 5'd4,  nwb: 4,  bad: 1,  v: mkv(0, 1, 0, 4'd1,  32'hB,  16'd2)};
    rows[2] = '{num: 5'd0,  nwb: 16, bad: -1, v: mkv(1, 0, 0, 4'd0,  32'h0,  16'd16)};
    rows[3] = '{num: 5'd1,  nwb: 1,  bad: -1, v: mkv(1, 0, 0, 4'd0,  32'h0,  16'd1)};
    rows[4] = '{num: 5'd16, nwb: 16, bad: 15, v: mkv(0, 1, 0, 4'd15, 32'h51, 16'd16)};
    rows[5] = '{num: 5'd3,  nwb: 3,  bad: 0,  v: mkv(0, 1, 0, 4'd0,  32'h6,  16'd1)};

    RN = 1'b0; start = 1'b0; num_exp = '0; exp_we = 1'b0; exp_addr = '0;
    exp_data = '0; npc = 32'h1000; wb_valid = 1'b0; wb_data = '0; done_q = 1'b0;
    step(); step();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_fail", fail, 1'b0);
    check("rst_hang", hang, 1'b0);
    check("rst_err_idx", err_idx, 4'd0);
    check("rst_err_got", err_got, 32'd0);
    check("rst_cycle_cnt", cycle_cnt, 16'd0);
    RN = 1'b1;
    step();

    for (int i = 0; i < 16; i++) begin
      exp_we = 1'b1; exp_addr = 4'(i); exp_data = 32'(5 * (i + 1));
      step();
    end
    exp_we = 1'b0;
    step();

    for (int r = 0; r < 6; r++) run_row(rows[r]);

    // Hang with npc frozen from the start: seeded on the first RUN cycle.
    npc = 32'h40; step();
    sb.push_back(mkv(0, 0, 1, 4'd0, 32'h0, 16'd8));
    start = 1'b1; num_exp = 5'd4; step(); start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("hang_seed_timing", hang, (k == 8));
      check("hang_seed_cnt", cycle_cnt, 16'(k));
    end
    step(); step();
    check("hang_hold", hang, 1'b1);
    check("hang_hold_cnt", cycle_cnt, 16'd8);

    // Hang after npc moves a few times.
    sb.push_back(mkv(0, 0, 1, 4'd0, 32'h0, 16'd10));
    do_start(5'd4);
    npc = 32'h100; step();
    npc = 32'h104; step();
    npc = 32'h108;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("hang_change_timing", hang, (k == 8));
    end

    // Final match on the stall-limit cycle: pass wins.
    npc = 32'h200;
    sb.push_back(mkv(1, 0, 0, 4'd0, 32'h0, 16'd8));
    start = 1'b1; num_exp = 5'd1; step(); start = 1'b0;
    for (int k = 0; k < 7; k++) step();
    wb_valid = 1'b1; wb_data = 32'h5; step(); wb_valid = 1'b0;
    check("simul_pass", pass, 1'b1);
    check("simul_pass_nohang", hang, 1'b0);
    step();

    // Mismatch on the stall-limit cycle: fail wins.
    sb.push_back(mkv(0, 1, 0, 4'd0, 32'h6, 16'd8));
    start = 1'b1; num_exp = 5'd1; step(); start = 1'b0;
    for (int k = 0; k < 7; k++) step();
    wb_valid = 1'b1; wb_data = 32'h6; step(); wb_valid = 1'b0;
    check("simul_fail", fail, 1'b1);
    check("simul_fail_nohang", hang, 1'b0);
    step();

    // Asynchronous reset with idx=2, then a clean rerun from entry 0.
    do_start(5'd4);
    wb_valid = 1'b1; wb_data = 32'h5; npc = npc + 4; step();
    wb_data = 32'hA; npc = npc + 4; step();
    wb_valid = 1'b0;
    check("pre_rst_busy", busy, 1'b1);
    #2 RN = 1'b0;
    #1;
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_cnt", cycle_cnt, 16'd0);
    check("async_rst_done", done, 1'b0);
    #1 RN = 1'b1;
    step();
    run_row(rows[0]);

    // exp_we during RUN must not alter entry 1.
    sb.push_back(mkv(1, 0, 0, 4'd0, 32'h0, 16'd2));
    do_start(5'd2);
    wb_valid = 1'b1; wb_data = 32'h5; exp_we = 1'b1; exp_addr = 4'd1;
    exp_data = 32'hBAD; npc = npc + 4; step();
    exp_we = 1'b0; wb_data = 32'hA; npc = npc + 4; step();
    wb_valid = 1'b0;
    check("locked_write_pass", pass, 1'b1);
    npc = npc + 4; step();

    // Write and start together: the run sees the new value.
    sb.push_back(mkv(1, 0, 0, 4'd0, 32'h0, 16'd1));
    exp_we = 1'b1; exp_addr = 4'd0; exp_data = 32'h77;
    do_start(5'd1);
    exp_we = 1'b0;
    wb_valid = 1'b1; wb_data = 32'h77; npc = npc + 4; step();
    wb_valid = 1'b0;
    check("write_start_pass", pass, 1'b1);
    npc = npc + 4; step(); step();

    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
